ddr_pixel_prefetch: RTL

Read-side prefetcher between the DDR controller and the VGA pixel pipeline. It walks the frame buffer sequentially and issues single-word reads over the controller's level read/acknowledge handshake. Returned words go into a small show-ahead FIFO, and the VGA scan logic pops one 16-bit pixel per active pixel slot. The FIFO absorbs the controller's variable access latency (activate/read/idle turnaround).

---
 rtl/ddr_pixel_prefetch.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ddr_pixel_prefetch.sv
// Sequential frame-buffer read prefetcher feeding the VGA pixel pipeline through a show-ahead FIFO.
// Optional build macro: PREFETCH_UNDERFLOW_COUNT_EN adds a saturating underflowCount output.
module ddr_pixel_prefetch #(
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter int          FRAME_WORDS = 307200,
  parameter int          DEPTH_LOG2  = 4
) (
  input  logic        clk133_p,
  input  logic        rst,
  input  logic        enable,
  input  logic        frameStart,
  input  logic        pixelPop,
  output logic [15:0] pixelData,
  output logic        pixelValid,
  output logic        underflow,
  output logic        read,
  output logic [23:0] readAddress,
  input  logic        readAcknowledge,
  input  logic [15:0] readData,
`ifdef PREFETCH_UNDERFLOW_COUNT_EN
  output logic [15:0] underflowCount,
`endif
  output logic [1:0]  fsm_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int IW    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         index_q, index_d, index_next;
  logic                  drop_q, drop_d;
  logic                  push, pop;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [15:0]           mem [DEPTH];

  // Handshake: read is a level request held with a stable readAddress until
  // readAcknowledge is sampled high (readData valid in that cycle); the next
  // request is issued only after the acknowledge has been seen low again.
  assign read        = (state_q == REQ);
  assign readAddress = BASE_ADDR + 24'(index_q);
  assign fsm_state   = state_q;
  assign index_next  = (index_q == IW'(FRAME_WORDS - 1)) ? '0 : index_q + 1'b1;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    drop_d  = drop_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (count_q < (DEPTH_LOG2+1)'(DEPTH)) && !readAcknowledge) state_d = REQ;
      end
      REQ: begin
        if (readAcknowledge) begin
          push    = !drop_q && !frameStart;
          drop_d  = 1'b0;
          index_d = (drop_q || frameStart) ? '0 : index_next;
          state_d = RELEASE;
        end else if (frameStart) begin
          // address must stay stable while read is high; restart after the ack
          drop_d = 1'b1;
        end
      end
      RELEASE: begin
        if (!readAcknowledge) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (frameStart && state_q != REQ) index_d = '0;
  end

  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      drop_q  <= drop_d;
    end
  end

  assign pop = pixelPop && (count_q != '0) && !frameStart;

  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (frameStart) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk133_p) begin
    if (push) mem[wr_ptr_q] <= readData;
  end

  assign pixelValid = (count_q != '0);
  assign pixelData  = pixelValid ? mem[rd_ptr_q] : 16'h0000;

  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst)                                  underflow <= 1'b0;
    else if (frameStart)                      underflow <= 1'b0;
    else if (pixelPop && count_q == '0)       underflow <= 1'b1;
  end

`ifdef PREFETCH_UNDERFLOW_COUNT_EN
  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst)                        underflowCount <= 16'h0000;
    else if (frameStart)            underflowCount <= 16'h0000;
    else if (pixelPop && count_q == '0 && underflowCount != 16'hFFFF)
                                    underflowCount <= underflowCount + 16'h0001;
  end
`endif

endmodule
